// File: rtl/sddr_phy_pkg.sv
// Shared types and constants for the DDR3 PHY data-path sequencer.
package sddr_phy_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_WR,
    SLOT_RD
  } slot_dir_e;

  localparam int BURST_CLKS = 4;
  localparam int MIN_LAT    = 5;

endpackage

// File: rtl/sddr_slot_sched.sv
// Bus slot schedule: one slot per future DDR clock, collision check and position taps.
// RD_EXT widens the read guard band when per-lane deskew delays read capture.
module sddr_slot_sched
  import sddr_phy_pkg::*;
#(
  parameter int LAT_MAX = 15,
  parameter int LAT_W   = $clog2(LAT_MAX + 1),
  parameter int RD_EXT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LAT_W-1:0] cfg_cwl,
  input  logic [LAT_W-1:0] cfg_cl,
  input  logic             cmd_valid,
  input  logic             cmd_write,
  output logic             cmd_error,
  output slot_dir_e        tap0,
  output slot_dir_e        tap1
);

  localparam int DEPTH = LAT_MAX + 6 + RD_EXT;

  slot_dir_e        slot_q [DEPTH];
  logic [LAT_W-1:0] cwl_q, cl_q, cwl_eff, cl_eff;
  logic             sched_idle, reject, accept;
  int               lat_i;

  always_comb begin
    sched_idle = 1'b1;
    for (int k = 0; k < DEPTH; k++)
      if (slot_q[k] != SLOT_IDLE) sched_idle = 1'b0;
  end

  // Latencies only follow the config inputs while nothing is in flight.
  assign cwl_eff = sched_idle ? cfg_cwl : cwl_q;
  assign cl_eff  = sched_idle ? cfg_cl  : cl_q;

  always_comb begin
    lat_i  = cmd_write ? int'(cwl_eff) : int'(cl_eff);
    reject = (lat_i < MIN_LAT) || (lat_i > LAT_MAX);
    for (int k = 0; k < DEPTH; k++) begin
      if (k >= lat_i && k < lat_i + BURST_CLKS && slot_q[k] != SLOT_IDLE) reject = 1'b1;
      if (cmd_write) begin
        if (slot_q[k] == SLOT_RD &&
            ((k >= lat_i - 1 - RD_EXT && k <= lat_i - 1) || k == lat_i + BURST_CLKS))
          reject = 1'b1;
      end else begin
        if (slot_q[k] == SLOT_WR &&
            (k == lat_i - 1 || (k >= lat_i + BURST_CLKS && k <= lat_i + BURST_CLKS + RD_EXT)))
          reject = 1'b1;
      end
    end
  end

  assign accept = cmd_valid && !reject;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= SLOT_IDLE;
      cwl_q     <= '0;
      cl_q      <= '0;
      cmd_error <= 1'b0;
    end else begin
      // Position k after the shift holds the slot k+1 clocks after the command.
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (accept && (k + 1 >= lat_i) && (k + 1 < lat_i + BURST_CLKS))
          slot_q[k] <= cmd_write ? SLOT_WR : SLOT_RD;
        else
          slot_q[k] <= slot_q[k+1];
      end
      slot_q[DEPTH-1] <= SLOT_IDLE;
      if (sched_idle) begin
        cwl_q <= cfg_cwl;
        cl_q  <= cfg_cl;
      end
      cmd_error <= cmd_valid && reject;
    end
  end

  assign tap0 = slot_q[0];
  assign tap1 = slot_q[1];

endmodule

// File: rtl/sddr_phy_datapath.sv
// DDR3 BL8 data-path sequencer between controller and ODDR/IDDR/IOBUF primitives.
// Optional SDDR_PHY_DESKEW_EN adds per-lane read capture delay with realignment.
module sddr_phy_datapath
  import sddr_phy_pkg::*;
#(
  parameter int  LANES     = 2,
  parameter int  LAT_MAX   = 15,
  localparam int DATA_BITS = LANES * 8,
  localparam int LAT_W     = $clog2(LAT_MAX + 1)
) (
  input  logic                   in_ddr_clock_i,
  input  logic                   in_phy_reset_i,
  input  logic [LAT_W-1:0]       cfg_cwl_i,
  input  logic [LAT_W-1:0]       cfg_cl_i,
`ifdef SDDR_PHY_DESKEW_EN
  input  logic [2*LANES-1:0]     cfg_lane_delay_i,
`endif
  input  logic                   ctl_cmd_valid_i,
  input  logic                   ctl_cmd_write_i,
  output logic                   ctl_cmd_error_o,
  output logic                   ctl_wdata_req_o,
  input  logic [2*DATA_BITS-1:0] ctl_wdata_i,
  output logic [2*DATA_BITS-1:0] ctl_rdata_o,
  output logic                   ctl_rdata_valid_o,
  output logic [2*DATA_BITS-1:0] io_dq_o,
  output logic                   io_dq_oe_o,
  output logic                   io_dqs_oe_o,
  output logic                   io_dqs_toggle_o,
  input  logic [2*DATA_BITS-1:0] io_dq_i
);

`ifdef SDDR_PHY_DESKEW_EN
  localparam int RD_EXT = 3;
`else
  localparam int RD_EXT = 0;
`endif

  slot_dir_e              tap0, tap1;
  logic                   wr_now, wr_next, rd_now, wr_prev, rd_d1, rd_cap;
  logic [2*DATA_BITS-1:0] rd_tap;

  sddr_slot_sched #(.LAT_MAX(LAT_MAX), .LAT_W(LAT_W), .RD_EXT(RD_EXT)) u_sched (
    .clk       (in_ddr_clock_i),
    .rst       (in_phy_reset_i),
    .cfg_cwl   (cfg_cwl_i),
    .cfg_cl    (cfg_cl_i),
    .cmd_valid (ctl_cmd_valid_i),
    .cmd_write (ctl_cmd_write_i),
    .cmd_error (ctl_cmd_error_o),
    .tap0      (tap0),
    .tap1      (tap1)
  );

  assign wr_now  = (tap0 == SLOT_WR);
  assign wr_next = (tap1 == SLOT_WR);
  assign rd_now  = (tap0 == SLOT_RD);

  // Preamble from wr_next, postamble from wr_prev; adjacent bursts merge naturally.
  assign ctl_wdata_req_o = wr_next;
  assign io_dqs_toggle_o = wr_now;
  assign io_dqs_oe_o     = wr_next | wr_now | wr_prev;

  always_ff @(posedge in_ddr_clock_i or posedge in_phy_reset_i) begin
    if (in_phy_reset_i) begin
      wr_prev    <= 1'b0;
      io_dq_oe_o <= 1'b0;
      io_dq_o    <= '0;
      rd_d1      <= 1'b0;
    end else begin
      wr_prev    <= wr_now;
      io_dq_oe_o <= wr_next;
      io_dq_o    <= wr_next ? ctl_wdata_i : '0;
      rd_d1      <= rd_now;
    end
  end

`ifdef SDDR_PHY_DESKEW_EN
  logic [2:0]  rd_pipe;
  logic [15:0] lane_q [LANES][3];

  // Lane i arrives d_i clocks late, so it is taken 3-d_i clocks back in its history.
  always_comb begin
    rd_tap = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cfg_lane_delay_i[2*i +: 2] == 2'd3) begin
        rd_tap[i*8 +: 8]           = io_dq_i[i*8 +: 8];
        rd_tap[DATA_BITS+i*8 +: 8] = io_dq_i[DATA_BITS+i*8 +: 8];
      end else begin
        rd_tap[i*8 +: 8]           = lane_q[i][2'd2 - cfg_lane_delay_i[2*i +: 2]][7:0];
        rd_tap[DATA_BITS+i*8 +: 8] = lane_q[i][2'd2 - cfg_lane_delay_i[2*i +: 2]][15:8];
      end
    end
  end

  always_ff @(posedge in_ddr_clock_i or posedge in_phy_reset_i) begin
    if (in_phy_reset_i) begin
      rd_pipe <= '0;
      for (int i = 0; i < LANES; i++)
        for (int k = 0; k < 3; k++) lane_q[i][k] <= '0;
    end else begin
      rd_pipe <= {rd_pipe[1:0], rd_d1};
      for (int i = 0; i < LANES; i++) begin
        lane_q[i][0] <= {io_dq_i[DATA_BITS+i*8 +: 8], io_dq_i[i*8 +: 8]};
        lane_q[i][1] <= lane_q[i][0];
        lane_q[i][2] <= lane_q[i][1];
      end
    end
  end

  assign rd_cap = rd_pipe[2];
`else
  assign rd_tap = io_dq_i;
  assign rd_cap = rd_d1;
`endif

  always_ff @(posedge in_ddr_clock_i or posedge in_phy_reset_i) begin
    if (in_phy_reset_i) begin
      ctl_rdata_valid_o <= 1'b0;
      ctl_rdata_o       <= '0;
    end else begin
      ctl_rdata_valid_o <= rd_cap;
      if (rd_cap) ctl_rdata_o <= rd_tap;
    end
  end

endmodule

// File: tb/tb_sddr_phy_datapath.sv
// Scoreboard bench for sddr_phy_datapath: expected beats queued at command issue, popped on output.
module tb_sddr_phy_datapath;

  localparam int LANES = 2;
  localparam int DW    = 2 * LANES * 8;
  localparam int MAXC  = 512;
`ifdef SDDR_PHY_DESKEW_EN
  localparam int RDX = 3;
`else
  localparam int RDX = 0;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cfg_cwl, cfg_cl;
  logic [3:0]    lane_dly;
  logic          cmd_valid, cmd_write;
  logic          cmd_error, wdata_req, rdata_valid, dq_oe, dqs_oe, dqs_tog;
  logic [DW-1:0] wdata, rdata, dq_out, dq_in;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    exp_err [MAXC];
  bit    exp_req [MAXC];
  bit    exp_dqoe [MAXC];
  bit    exp_dqsoe [MAXC];
  bit    exp_tog [MAXC];
  bit    exp_val [MAXC];
  logic [31:0] wd_at [MAXC];
  logic [31:0] di_at [MAXC];
  beat_t wq [$];
  beat_t rq [$];
  beat_t wit, rit;

  sddr_phy_datapath #(.LANES(LANES), .LAT_MAX(15)) dut (
    .in_ddr_clock_i    (clk),
    .in_phy_reset_i    (rst),
    .cfg_cwl_i         (cfg_cwl),
    .cfg_cl_i          (cfg_cl),
`ifdef SDDR_PHY_DESKEW_EN
    .cfg_lane_delay_i  (lane_dly),
`endif
    .ctl_cmd_valid_i   (cmd_valid),
    .ctl_cmd_write_i   (cmd_write),
    .ctl_cmd_error_o   (cmd_error),
    .ctl_wdata_req_o   (wdata_req),
    .ctl_wdata_i       (wdata),
    .ctl_rdata_o       (rdata),
    .ctl_rdata_valid_o (rdata_valid),
    .io_dq_o           (dq_out),
    .io_dq_oe_o        (dq_oe),
    .io_dqs_oe_o       (dqs_oe),
    .io_dqs_toggle_o   (dqs_tog),
    .io_dq_i           (dq_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at the negedge of the command cycle; lat is the latency the command must use.
  task automatic issue(input bit wr, input int lat, input bit ok);
    int t;
    t = cyc;
    cmd_valid = 1'b1;
    cmd_write = wr;
    if (!ok) begin
      exp_err[t+1] = 1'b1;
    end else if (wr) begin
      for (int j = 0; j < 4; j++) begin
        wd_at[t+lat-1+j]  = 32'h1111_1111 * (j + 1);
        exp_req[t+lat-1+j] = 1'b1;
        exp_dqoe[t+lat+j]  = 1'b1;
        exp_tog[t+lat+j]   = 1'b1;
        wq.push_back('{t+lat+j, wd_at[t+lat-1+j]});
      end
      for (int j = -1; j < 5; j++) exp_dqsoe[t+lat+j] = 1'b1;
    end else begin
      for (int j = 0; j < 4; j++) begin
        di_at[t+lat+1+j] = {16'hA5A5, 8'(t), 8'(j)};
        exp_val[t+lat+2+RDX+j] = 1'b1;
        rq.push_back('{t+lat+2+RDX+j, di_at[t+lat+1+j]});
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Asynchronous reset a little after the edge that starts cycle c; in-flight work is lost.
  task automatic pulse_reset(input int c);
    wait_until(c - 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int k = c; k < MAXC; k++) begin
      exp_err[k] = 0; exp_req[k] = 0; exp_dqoe[k] = 0;
      exp_dqsoe[k] = 0; exp_tog[k] = 0; exp_val[k] = 0;
    end
    wq.delete();
    rq.delete();
    #1;
    check_eq("rst_rdata", 64'(rdata), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      wdata = wd_at[cyc];
      dq_in = di_at[cyc];
    end
  end

  always @(negedge clk) begin
    if (cyc > 0 && cyc < MAXC) begin
      check_eq("ctl_vec", 64'({cmd_error, wdata_req, dq_oe, dqs_oe, dqs_tog, rdata_valid}),
               64'({exp_err[cyc], exp_req[cyc], exp_dqoe[cyc], exp_dqsoe[cyc], exp_tog[cyc], exp_val[cyc]}));
      if (dq_oe) begin
        check_eq("wq_avail", 64'(wq.size() != 0), 64'(1));
        if (wq.size() != 0) begin
          wit = wq.pop_front();
          check_eq("wdq_cyc", 64'(cyc), 64'(wit.cyc));
          check_eq("wdq_data", 64'(dq_out), 64'(wit.data));
        end
      end
      if (rdata_valid) begin
        check_eq("rq_avail", 64'(rq.size() != 0), 64'(1));
        if (rq.size() != 0) begin
          rit = rq.pop_front();
          check_eq("rd_cyc", 64'(cyc), 64'(rit.cyc));
          check_eq("rd_data", 64'(rdata), 64'(rit.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    cfg_cwl = 4'd5;
    cfg_cl = 4'd6;
    lane_dly = '0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    for (int k = 0; k < MAXC; k++) begin
      wd_at[k] = $urandom;
      di_at[k] = $urandom;
    end
    wdata = wd_at[0];
    dq_in = di_at[0];
    #1;
    check_eq("rst_data", {dq_out, rdata}, 64'(0));
    check_eq("rst_ctl", 64'({cmd_error, wdata_req, rdata_valid, dq_oe, dqs_oe, dqs_tog}), 64'(0));
    wait_until(3);
    rst = 1'b0;

    wait_until(10);  issue(1'b1, 5, 1'b1);
    wait_until(30);  issue(1'b0, 6, 1'b1);
    wait_until(50);  issue(1'b1, 5, 1'b1);
    wait_until(52);  issue(1'b1, 5, 1'b0);
    wait_until(54);  issue(1'b1, 5, 1'b1);

    wait_until(70);  cfg_cl = 4'd5;
    wait_until(80);  issue(1'b1, 5, 1'b1);
    wait_until(84);  issue(1'b0, 5, 1'b0);
    wait_until(85);  issue(1'b0, 5, 1'b1);

    wait_until(100); cfg_cwl = 4'd4;
    wait_until(110); issue(1'b1, 4, 1'b0);
    wait_until(120); cfg_cwl = 4'd15;
    wait_until(130); issue(1'b1, 15, 1'b1);
    wait_until(132); cfg_cwl = 4'd7;
    wait_until(134); issue(1'b1, 15, 1'b1);
    wait_until(170); issue(1'b1, 7, 1'b1);

    wait_until(185); cfg_cl = 4'd6;
    wait_until(200); issue(1'b0, 6, 1'b1);
    pulse_reset(209);
    wait_until(230); issue(1'b1, 7, 1'b1);
    pulse_reset(238);

    wait_until(270);
    check_eq("wq_left", 64'(wq.size()), 64'(0));
    check_eq("rq_left", 64'(rq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
